// File: rtl/hazard_unit.sv
// Decode-stage hazard controller: operand forwarding, load-use and FPU stalls, mispredict flushes.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
   parameter int FPU_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  rs0,
   input  logic [5:0]  rs1,
   input  logic        rs0_used,
   input  logic        rs1_used,
   input  logic        dec_valid,
   input  logic [5:0]  rdE,
   input  logic        regwriteE,
   input  logic        memreadE,
   input  logic [5:0]  rdM,
   input  logic        regwriteM,
   input  logic        fpu_issue,
   input  logic [5:0]  fpu_rd,
   input  logic        mispredict,
   output logic [1:0]  forward0,
   output logic [1:0]  forward1,
   output logic        stallF,
   output logic        stallD,
   output logic        flushD,
   output logic        flushE,
   output logic        fpu_busy,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {RUN, LD_STALL, FPU_WAIT} state_t;

   localparam logic [3:0] CNT_INIT = 4'(FPU_LAT - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [5:0] busy_rd;

   logic match0_e, match1_e, match0_m, match1_m;
   logic raw0, raw1, waw;
   logic busy_int, ld_hazard, fpu_hazard, stall_req;

   assign match0_e = rs0_used && regwriteE && (rs0 != 6'd0) && (rs0 == rdE);
   assign match1_e = rs1_used && regwriteE && (rs1 != 6'd0) && (rs1 == rdE);
   assign match0_m = rs0_used && regwriteM && (rs0 != 6'd0) && (rs0 == rdM);
   assign match1_m = rs1_used && regwriteM && (rs1 != 6'd0) && (rs1 == rdM);

   assign busy_int = (cnt != 4'd0);

   // The WAW check uses the destination of the instruction about to enter E.
   assign raw0 = rs0_used && (rs0 != 6'd0) && (rs0 == busy_rd);
   assign raw1 = rs1_used && (rs1 != 6'd0) && (rs1 == busy_rd);
   assign waw  = regwriteE && (rdE != 6'd0) && (rdE == busy_rd);

   assign ld_hazard  = dec_valid && memreadE && (match0_e || match1_e);
   assign fpu_hazard = busy_int && dec_valid && (raw0 || raw1 || waw);

   // The load-use bubble lasts one cycle; in LD_STALL the load has moved on to M.
   assign stall_req = (ld_hazard && (state != LD_STALL)) || fpu_hazard;

   always_comb begin
      forward0 = 2'b00;
      forward1 = 2'b00;
      stallF   = 1'b0;
      stallD   = 1'b0;
      flushD   = 1'b0;
      flushE   = 1'b0;
      fpu_busy = 1'b0;
      if (!rst) begin
         if (match0_e && !memreadE)
            forward0 = 2'b01;
         else if (match0_m)
            forward0 = 2'b10;
         if (match1_e && !memreadE)
            forward1 = 2'b01;
         else if (match1_m)
            forward1 = 2'b10;
         fpu_busy = busy_int;
         if (mispredict) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (stall_req) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else if (mispredict) begin
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (ld_hazard)
                  state <= LD_STALL;
               else if (fpu_hazard)
                  state <= FPU_WAIT;
            end
            LD_STALL: state <= RUN;
            FPU_WAIT: begin
               if (!fpu_hazard)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // An issued FPU op always writes back, so mispredict does not touch the scoreboard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 4'd0;
         busy_rd <= 6'd0;
      end else if (fpu_issue) begin
         cnt     <= CNT_INIT;
         busy_rd <= fpu_rd;
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         if (stallD)
            stall_cycles <= stall_cycles + 32'd1;
         if (mispredict)
            flush_count <= flush_count + 32'd1;
      end
   end
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: forwarding, load-use, FPU RAW/WAW, mispredict and reset.
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  rs0, rs1, rdE, rdM, fpu_rd;
   logic        rs0_used, rs1_used, dec_valid, regwriteE, memreadE, regwriteM;
   logic        fpu_issue, mispredict;
   logic [1:0]  forward0, forward1;
   logic        stallF, stallD, flushD, flushE, fpu_busy;
   logic [31:0] stall_cycles, flush_count;

   typedef struct {
      logic [1:0] fw0;
      logic [1:0] fw1;
      logic       stall;
      logic       flush_d;
      logic       flush_e;
      logic       busy;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_stalls = 32'd0;
   logic [31:0] exp_flushes = 32'd0;

   hazard_unit #(.FPU_LAT(4)) dut (
      .clk(clk), .rst(rst),
      .rs0(rs0), .rs1(rs1), .rs0_used(rs0_used), .rs1_used(rs1_used),
      .dec_valid(dec_valid), .rdE(rdE), .regwriteE(regwriteE), .memreadE(memreadE),
      .rdM(rdM), .regwriteM(regwriteM), .fpu_issue(fpu_issue), .fpu_rd(fpu_rd),
      .mispredict(mispredict), .forward0(forward0), .forward1(forward1),
      .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
      .fpu_busy(fpu_busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic clearInputs();
      rs0 = 6'd0; rs1 = 6'd0; rs0_used = 1'b0; rs1_used = 1'b0;
      dec_valid = 1'b0; rdE = 6'd0; regwriteE = 1'b0; memreadE = 1'b0;
      rdM = 6'd0; regwriteM = 1'b0; fpu_issue = 1'b0; fpu_rd = 6'd0;
      mispredict = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] fw0, input logic [1:0] fw1,
                                input logic stall, input logic fd, input logic fe,
                                input logic busy);
      exp_t e;
      e.fw0 = fw0; e.fw1 = fw1; e.stall = stall;
      e.flush_d = fd; e.flush_e = fe; e.busy = busy;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h required=%0h", tag, obs, req);
      end
   endtask

   // Outputs are sampled 1 time unit after the falling edge, well clear of the rising edge.
   task automatic checkOutput(input string tag);
      exp_t e;
      #1;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("[TB] FAIL %s observed=empty_queue required=entry", tag);
      end else begin
         total--;
         e = sb.pop_front();
         cmp({tag, ".forward0"}, 32'(forward0), 32'(e.fw0));
         cmp({tag, ".forward1"}, 32'(forward1), 32'(e.fw1));
         cmp({tag, ".stallF"},   32'(stallF),   32'(e.stall));
         cmp({tag, ".stallD"},   32'(stallD),   32'(e.stall));
         cmp({tag, ".flushD"},   32'(flushD),   32'(e.flush_d));
         cmp({tag, ".flushE"},   32'(flushE),   32'(e.flush_e));
         cmp({tag, ".fpu_busy"}, 32'(fpu_busy), 32'(e.busy));
`ifdef HAZARD_PERF_EN
         cmp({tag, ".stall_cycles"}, stall_cycles, exp_stalls);
         cmp({tag, ".flush_count"},  flush_count,  exp_flushes);
`else
         cmp({tag, ".stall_cycles"}, stall_cycles, 32'd0);
         cmp({tag, ".flush_count"},  flush_count,  32'd0);
`endif
         if (!rst) begin
            if (e.stall) exp_stalls = exp_stalls + 32'd1;
            if (mispredict) exp_flushes = exp_flushes + 32'd1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clearInputs();
      @(negedge clk);

      // Reset gates every output even with a forwarding match present.
      dec_valid = 1'b1; rs0 = 6'd5; rs0_used = 1'b1; rdE = 6'd5; regwriteE = 1'b1;
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("reset");

      rst = 1'b0;
      applyStimulus(2'b01, 2'b00, 0, 0, 0, 0); checkOutput("fwd_e");
      rdE = 6'd0;
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("fwd_zero_id");

      clearInputs(); dec_valid = 1'b1;
      rs1 = 6'h21; rs1_used = 1'b1; rdE = 6'h21; regwriteE = 1'b1; rdM = 6'h21; regwriteM = 1'b1;
      applyStimulus(2'b00, 2'b01, 0, 0, 0, 0); checkOutput("fwd_e_priority");
      regwriteE = 1'b0;
      applyStimulus(2'b00, 2'b10, 0, 0, 0, 0); checkOutput("fwd_m");
      rs1_used = 1'b0;
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("fwd_unused");

      // Load-use: one bubble, then the load forwards from M.
      clearInputs(); dec_valid = 1'b1;
      rs0 = 6'd7; rs0_used = 1'b1; rdE = 6'd7; regwriteE = 1'b1; memreadE = 1'b1;
      applyStimulus(2'b00, 2'b00, 1, 0, 1, 0); checkOutput("ld_stall");
      rdE = 6'd0; regwriteE = 1'b0; memreadE = 1'b0; rdM = 6'd7; regwriteM = 1'b1;
      applyStimulus(2'b10, 2'b00, 0, 0, 0, 0); checkOutput("ld_fwd_m");
      clearInputs();
      rs0 = 6'd7; rs0_used = 1'b1; rdE = 6'd7; regwriteE = 1'b1; memreadE = 1'b1;
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("ld_not_valid");

      // FPU RAW with FPU_LAT=4: stalls while cnt is 3, 2, 1.
      clearInputs(); fpu_issue = 1'b1; fpu_rd = 6'h23;
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("fpu_issue");
      clearInputs(); dec_valid = 1'b1; rs0 = 6'h23; rs0_used = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b00, 2'b00, 1, 0, 1, 1); checkOutput("fpu_raw_stall");
      end
      rdM = 6'h23; regwriteM = 1'b1;
      applyStimulus(2'b10, 2'b00, 0, 0, 0, 0); checkOutput("fpu_raw_done");

      // FPU WAW, interrupted by a mispredict that must not stop the countdown.
      clearInputs(); fpu_issue = 1'b1; fpu_rd = 6'h24;
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("waw_issue");
      clearInputs(); dec_valid = 1'b1; rdE = 6'h24; regwriteE = 1'b1;
      applyStimulus(2'b00, 2'b00, 1, 0, 1, 1); checkOutput("waw_stall");
      mispredict = 1'b1;
      applyStimulus(2'b00, 2'b00, 0, 1, 1, 1); checkOutput("waw_mispredict");
      mispredict = 1'b0;
      applyStimulus(2'b00, 2'b00, 1, 0, 1, 1); checkOutput("waw_resume");
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("waw_done");

      // Load-use with mispredict: flush wins and the FSM stays in RUN.
      clearInputs(); dec_valid = 1'b1;
      rs0 = 6'd7; rs0_used = 1'b1; rdE = 6'd7; regwriteE = 1'b1; memreadE = 1'b1;
      mispredict = 1'b1;
      applyStimulus(2'b00, 2'b00, 0, 1, 1, 0); checkOutput("ld_mispredict");
      mispredict = 1'b0;
      applyStimulus(2'b00, 2'b00, 1, 0, 1, 0); checkOutput("ld_after_mispredict");

      // Issue alongside mispredict is still recorded; then reset mid-wait.
      clearInputs(); fpu_issue = 1'b1; fpu_rd = 6'h25; mispredict = 1'b1;
      applyStimulus(2'b00, 2'b00, 0, 1, 1, 0); checkOutput("issue_mispredict");
      clearInputs(); dec_valid = 1'b1; rs1 = 6'h25; rs1_used = 1'b1; rdM = 6'h25;
      applyStimulus(2'b00, 2'b00, 1, 0, 1, 1); checkOutput("fpu_raw_wait");
      rst = 1'b1; regwriteM = 1'b1;
      exp_stalls = 32'd0; exp_flushes = 32'd0;
      applyStimulus(2'b00, 2'b00, 0, 0, 0, 0); checkOutput("reset_mid_wait");
      rst = 1'b0;
      applyStimulus(2'b00, 2'b10, 0, 0, 0, 0); checkOutput("reset_release");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
